// File: rtl/axi3_rd_arbiter.sv
// axi3_rd_arbiter: shares one AXI3 read port among NUM_REQ requesters
// (icache refill, dcache refill, stream_buffer prefetch). At most one burst
// is in flight: the winner's AR fields are captured, issued on the master
// port, and its R beats are steered back using the registered grant index.
//
// Optional feature: define AXI_RD_ARB_FIXED_PRIO_EN to give requester 0
// absolute priority; requesters 1..NUM_REQ-1 then share round-robin.
module axi3_rd_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int BUS_WIDTH  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // requester AR channels
  input  logic [NUM_REQ-1:0]            s_arvalid,
  output logic [NUM_REQ-1:0]            s_arready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_REQ*4-1:0]          s_arlen,
  input  logic [NUM_REQ*3-1:0]          s_arsize,
  input  logic [NUM_REQ*2-1:0]          s_arburst,
  // requester R channels (data/resp/last shared)
  output logic [NUM_REQ-1:0]            s_rvalid,
  input  logic [NUM_REQ-1:0]            s_rready,
  output logic [DATA_WIDTH-1:0]         s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rlast,
  // master AR channel
  output logic [BUS_WIDTH-1:0]          m_arid,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic [3:0]                    m_arlen,
  output logic [2:0]                    m_arsize,
  output logic [1:0]                    m_arburst,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  // master R channel
  input  logic [BUS_WIDTH-1:0]          m_rid,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rlast,
  input  logic                          m_rvalid,
  output logic                          m_rready
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = GW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                state;
  logic [GW-1:0]         ptr;
  logic [GW-1:0]         g;
  logic                  in_data;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;

  logic                  found;
  logic [GW-1:0]         pick;
  logic [SW-1:0]         sum;
  logic [GW-1:0]         ptr_next;

  // Beats are steered by the registered grant only, so the returned ID is
  // deliberately ignored.
  logic unused_rid;
  assign unused_rid = ^m_rid;

  // Per-requester views of the packed AR buses.
  logic [ADDR_WIDTH-1:0] req_addr  [NUM_REQ];
  logic [3:0]            req_len   [NUM_REQ];
  logic [2:0]            req_size  [NUM_REQ];
  logic [1:0]            req_burst [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_addr[i]  = s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_len[i]   = s_arlen[i*4 +: 4];
    assign req_size[i]  = s_arsize[i*3 +: 3];
    assign req_burst[i] = s_arburst[i*2 +: 2];
  end

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
  logic [GW-1:0] base;

  // Winner search: requester 0 first, then round-robin over 1..NUM_REQ-1.
  always_comb begin
    // NOTE: combinational logic uses blocking assignments and gives every
    // output a default first, so no latch is inferred on any path.
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    base  = (ptr == '0) ? GW'(1) : ptr;
    if (s_arvalid[0]) begin
      found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        sum = {1'b0, base} + SW'(k);
        if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ - 1);
        if (!found && s_arvalid[sum[GW-1:0]]) begin
          found = 1'b1;
          pick  = sum[GW-1:0];
        end
      end
    end
  end

  // Pointer after a burst: unchanged for requester 0, else next in 1..N-1.
  always_comb begin
    if (g == '0) begin
      ptr_next = ptr;
    end else if (g == GW'(NUM_REQ - 1)) begin
      ptr_next = GW'(1);
    end else begin
      ptr_next = g + 1'b1;
    end
  end
`else
  // Winner search: first valid requester at or after ptr, wrapping at NUM_REQ.
  always_comb begin
    // NOTE: combinational logic uses blocking assignments and gives every
    // output a default first, so no latch is inferred on any path.
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      if (!found && s_arvalid[sum[GW-1:0]]) begin
        found = 1'b1;
        pick  = sum[GW-1:0];
      end
    end
  end

  // Pointer after a burst: the requester following the one just served.
  always_comb begin
    if (g == GW'(NUM_REQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = g + 1'b1;
    end
  end
`endif

  // Control FSM: capture winner in IDLE, issue AR in ADDR, stream R in DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register, including the captured AR fields, is cleared by
    // reset so a burst abandoned mid-flight leaves nothing behind.
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      g         <= '0;
      m_arvalid <= 1'b0;
      in_data   <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      case (state)
        IDLE: begin
          if (found) begin
            g         <= pick;
            addr_q    <= req_addr[pick];
            len_q     <= req_len[pick];
            size_q    <= req_size[pick];
            burst_q   <= req_burst[pick];
            m_arvalid <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            in_data   <= 1'b1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (m_rvalid && m_rready && m_rlast) begin
            in_data <= 1'b0;
            ptr     <= ptr_next;
            state   <= IDLE;
          end
        end
        default: begin
          m_arvalid <= 1'b0;
          in_data   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign m_arid    = BUS_WIDTH'(g);
  assign m_araddr  = addr_q;
  assign m_arlen   = len_q;
  assign m_arsize  = size_q;
  assign m_arburst = burst_q;

  // Handshake and R-valid steering: only the granted bit can ever be set.
  always_comb begin
    s_arready = '0;
    s_rvalid  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g == GW'(i)) begin
        s_arready[i] = m_arvalid & m_arready;
        s_rvalid[i]  = in_data & m_rvalid;
      end
    end
  end

  assign m_rready = in_data & s_rready[g];
  assign s_rdata  = in_data ? m_rdata : '0;
  assign s_rresp  = in_data ? m_rresp : 2'b00;
  assign s_rlast  = in_data & m_rlast;

endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// Self-checking bench for axi3_rd_arbiter: directed scenarios, a routing
// vector table, and randomized bursts scored against an arithmetic model of
// the arbitration rules.
module tb_axi3_rd_arbiter;

  localparam int N  = 3;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N*AW-1:0] s_araddr;
  logic [N*4-1:0]  s_arlen;
  logic [N*3-1:0]  s_arsize;
  logic [N*2-1:0]  s_arburst;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rlast;
  logic [IW-1:0]   m_arid, m_rid;
  logic [AW-1:0]   m_araddr;
  logic [3:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;
  logic            m_arvalid, m_arready;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rlast, m_rvalid, m_rready;

  always #5 clk = ~clk;

  axi3_rd_arbiter #(.NUM_REQ(N), .BUS_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr;

  logic [AW-1:0] r_addr  [N];
  logic [3:0]    r_len   [N];
  logic [2:0]    r_size  [N];
  logic [1:0]    r_burst [N];

  typedef struct {
    logic         rv;
    logic [N-1:0] rr;
    logic [IW-1:0] rid;
    logic [N-1:0] exp_sv;
    logic         exp_mr;
  } rt_vec_t;

  rt_vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      s_araddr[i*AW +: AW] = r_addr[i];
      s_arlen[i*4 +: 4]    = r_len[i];
      s_arsize[i*3 +: 3]   = r_size[i];
      s_arburst[i*2 +: 2]  = r_burst[i];
    end
  endtask

  // Arbitration rule: first valid requester scanning from the pointer.
  function automatic int model_pick(input logic [N-1:0] v, input int p);
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    int start;
    if (v[0]) return 0;
    start = (p < 1) ? 1 : p;
    for (int k = 0; k < N - 1; k++) begin
      int i;
      i = 1 + ((start - 1 + k) % (N - 1));
      if (v[i]) return i;
    end
`else
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
`endif
    return -1;
  endfunction

  function automatic int model_next(input int gnt, input int p);
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    return (gnt == 0) ? p : (gnt % (N - 1)) + 1;
`else
    return (gnt + 1) % N;
`endif
  endfunction

  // One complete burst starting in IDLE with s_arvalid already driven.
  task automatic burst(input int ar_stall, input bit throttle, input bit retract, output int g_seen);
    int g, len, beats, cyc;
    logic [AW-1:0] exp_addr;
    g = model_pick(s_arvalid, model_ptr);
    g_seen = -1;
    if (g < 0) return;
    len      = int'(r_len[g]);
    exp_addr = r_addr[g];
    tick();
    check("ar_latency", m_arvalid, 1);
    g_seen = int'(m_arid);
    check("m_arid", m_arid, g);
    check("m_araddr", m_araddr, exp_addr);
    check("m_arlen", m_arlen, r_len[g]);
    check("m_arsize", m_arsize, r_size[g]);
    check("m_arburst", m_arburst, r_burst[g]);
    if (retract) begin
      s_arvalid[g] = 1'b0;
      r_addr[g] = ~r_addr[g];
      drive_req();
    end
    for (int s = 0; s < ar_stall; s++) begin
      #1;
      check("stall_arready", s_arready, 0);
      check("stall_arvalid", m_arvalid, 1);
      check("stall_araddr", m_araddr, exp_addr);
      check("stall_arlen", m_arlen, len);
      tick();
    end
    m_arready = 1'b1;
    #1;
    check("arready_pulse", s_arready, 64'd1 << g);
    tick();
    m_arready = 1'b0;
    check("arvalid_drop", m_arvalid, 0);
    beats = 0;
    cyc   = 0;
    while (beats <= len && cyc < 64) begin
      m_rvalid = 1'b1;
      m_rid    = IW'($urandom);
      m_rdata  = $urandom;
      m_rresp  = 2'($urandom);
      m_rlast  = (beats == len);
      s_rready = N'($urandom);
      s_rready[g] = !throttle || (cyc % 2 == 0);
      #1;
      check("s_rvalid_route", s_rvalid, 64'd1 << g);
      check("m_rready_track", m_rready, s_rready[g]);
      check("s_rdata_pass", s_rdata, m_rdata);
      check("s_rresp_pass", s_rresp, m_rresp);
      check("s_rlast_pass", s_rlast, m_rlast);
      if (s_rready[g]) beats++;
      tick();
      cyc++;
    end
    check("beat_count", beats, len + 1);
    m_rvalid = 1'b1;
    m_rlast  = 1'b0;
    s_rready = '1;
    #1;
    check("idle_rvalid", s_rvalid, 0);
    check("idle_rready", m_rready, 0);
    check("no_same_cycle_grant", m_arvalid, 0);
    m_rvalid = 1'b0;
    model_ptr = model_next(g, model_ptr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gs;
    int exp_contend[6];
    int exp_alt[4];
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    exp_contend = '{0, 0, 0, 0, 0, 0};
`else
    exp_contend = '{0, 1, 2, 0, 1, 2};
`endif
    exp_alt = '{1, 2, 1, 2};
    //            rv  rr      rid    exp_sv  exp_mr   (granted requester = 1)
    vecs[0] = '{1'b0, 3'b111, 4'd0, 3'b000, 1'b1};
    vecs[1] = '{1'b1, 3'b010, 4'd2, 3'b010, 1'b1};
    vecs[2] = '{1'b1, 3'b101, 4'd1, 3'b010, 1'b0};
    vecs[3] = '{1'b0, 3'b000, 4'd0, 3'b000, 1'b0};
    vecs[4] = '{1'b1, 3'b111, 4'd0, 3'b010, 1'b1};
    vecs[5] = '{1'b1, 3'b011, 4'd15, 3'b010, 1'b1};

    rst_n = 1'b0;
    s_arvalid = '1; s_rready = '1;
    m_arready = 1'b1; m_rid = '0; m_rdata = 32'hdead_beef; m_rresp = 2'b10;
    m_rlast = 1'b1; m_rvalid = 1'b1;
    for (int i = 0; i < N; i++) begin
      r_addr[i] = 32'h100 * (i + 1); r_len[i] = 4'd3; r_size[i] = 3'd2; r_burst[i] = 2'd1;
    end
    drive_req();
    repeat (2) tick();
    check("rst_arvalid", m_arvalid, 0);
    check("rst_rready", m_rready, 0);
    check("rst_arready", s_arready, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_araddr", m_araddr, 0);
    check("rst_arid", m_arid, 0);
    check("rst_arlen", m_arlen, 0);
    check("rst_rdata", s_rdata, 0);
    s_arvalid = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
    rst_n = 1'b1;
    model_ptr = 0;
    tick();
    check("idle_after_rst", m_arvalid, 0);

    // Single request from requester 2, 8 beats, requester retracts.
    r_addr[2] = 32'h0000_1000; r_len[2] = 4'd7;
    drive_req();
    s_arvalid = 3'b100;
    burst(0, 1'b0, 1'b1, gs);
    check("single_grant", gs, 2);
    tick();
    check("idle_no_request", m_arvalid, 0);

    // Contention, all valid, arlen=3.
    for (int i = 0; i < N; i++) begin
      r_addr[i] = 32'h2000 + 32'h40 * i; r_len[i] = 4'd3;
    end
    drive_req();
    s_arvalid = 3'b111;
    for (int b = 0; b < 6; b++) begin
      burst(0, 1'b0, 1'b0, gs);
      check("contend_order", gs, exp_contend[b]);
    end

    // Requester 0 idle: 1 and 2 alternate.
    s_arvalid = 3'b110;
    for (int b = 0; b < 4; b++) begin
      burst(0, 1'b0, 1'b0, gs);
      check("alt_order", gs, exp_alt[b]);
    end

    // Lone requester back-to-back with single-beat bursts.
    r_len[1] = 4'd0;
    drive_req();
    s_arvalid = 3'b010;
    for (int b = 0; b < 3; b++) begin
      burst(0, 1'b0, 1'b0, gs);
      check("lone_regrant", gs, 1);
    end

    // Routing table while requester 1 holds the DATA phase.
    r_len[1] = 4'd7;
    drive_req();
    s_arvalid = 3'b010;
    tick();
    check("tbl_arid", m_arid, 1);
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    s_arvalid = '0;
    for (int v = 0; v < 6; v++) begin
      m_rvalid = vecs[v].rv; s_rready = vecs[v].rr; m_rid = vecs[v].rid;
      m_rdata = 32'h5a00_0000 + v; m_rlast = 1'b0;
      #1;
      check("tbl_s_rvalid", s_rvalid, vecs[v].exp_sv);
      check("tbl_m_rready", m_rready, vecs[v].exp_mr);
      check("tbl_s_rdata", s_rdata, 32'h5a00_0000 + v);
    end
    m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = '1;
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    model_ptr = model_next(1, model_ptr);
    #1;
    check("tbl_back_idle", m_rready, 0);

    // AR backpressure and 1-of-2 R throttling.
    s_arvalid = 3'b101;
    burst(5, 1'b1, 1'b0, gs);

    // Randomized bursts against the model.
    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < N; i++) begin
        r_addr[i] = $urandom; r_len[i] = 4'($urandom_range(0, 7));
        r_size[i] = 3'($urandom); r_burst[i] = 2'($urandom);
      end
      drive_req();
      s_arvalid = N'($urandom_range(1, 7));
      burst($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), gs);
    end

    // Reset mid-burst: move ptr to 2, abandon a burst of requester 0.
    s_arvalid = 3'b010;
    burst(0, 1'b0, 1'b1, gs);
    r_len[0] = 4'd7;
    drive_req();
    s_arvalid = 3'b001;
    tick();
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    s_arvalid = '0;
    m_rvalid = 1'b1; s_rready = '1; m_rlast = 1'b0; m_rdata = 32'hcafe_f00d;
    repeat (3) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_arvalid", m_arvalid, 0);
    check("midrst_rready", m_rready, 0);
    check("midrst_rvalid", s_rvalid, 0);
    check("midrst_arready", s_arready, 0);
    check("midrst_rdata", s_rdata, 0);
    check("midrst_araddr", m_araddr, 0);
    m_rvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    model_ptr = 0;
    s_arvalid = 3'b110;
    burst(0, 1'b0, 1'b0, gs);
    check("rst_restart_grant", gs, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
